// File: rtl/parity_alarm_seq_pkg.sv
// ---------------------------------------------------------------------------
// parity_alarm_seq_pkg
// Shared AGC control definitions used by the parity alarm sequencer:
//   - pa_state_e        : sequencer state encoding
//   - PA_RST_CYCLES_DEF : default length of the restart request (CLK2 cycles)
//   - PA_WAIT_RETRY     : cycles spent in WAITLOW before the clear is retried
//   - PA_DCNT_W         : width of the shared down-counter (covers 1..255)
//   - pa_load()         : down-counter load value for an N-cycle interval
// ---------------------------------------------------------------------------
package parity_alarm_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUAL    = 3'd1,
    ST_RESTART = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_WAITLOW = 3'd4
  } pa_state_e;

  localparam int unsigned PA_RST_CYCLES_DEF = 8;
  localparam int unsigned PA_WAIT_RETRY     = 4;
  localparam int unsigned PA_DCNT_W         = 8;

  // An interval of n cycles counts down from n-1 to 0 inclusive.
  function automatic logic [PA_DCNT_W-1:0] pa_load(input int unsigned n);
    return PA_DCNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/parity_alarm_seq_ng_sync2.sv
// ---------------------------------------------------------------------------
// ng_sync2
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i  in  destination clock
//   rst_ni in  asynchronous active-low reset (both flops forced to 0)
//   d_i    in  asynchronous input level
//   q_o    out synchronized level, two clk_i edges of latency
// ---------------------------------------------------------------------------
module ng_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/parity_alarm_seq.sv
// ---------------------------------------------------------------------------
// parity_alarm_seq
// Parity alarm sequencer: qualifies the parity alarm, requests a restart for
// RST_CYCLES cycles, pulses the checker clear, then waits for the alarm to
// drop (retrying the clear while it stays high). Counts and lamps alarms.
// Parameters:
//   RST_CYCLES  restart request length in CLK2 cycles (legal 2..255)
//   CNT_W       width of the saturating alarm counter
// Ports:
//   CLK2        in  system clock, rising edge
//   PR_RST      in  asynchronous active-low reset
//   PARALM      in  parity alarm level (asynchronous)
//   ALM_INH     in  blocks acceptance of new alarms while high
//   ALM_ACK     in  operator acknowledge, clears the lamp
//   CLR_PAR_ALM out active-low one-cycle clear to the checker alarm latch
//   RESTART_REQ out restart request, RST_CYCLES cycles per accepted alarm
//   ALM_LAMP    out sticky alarm indicator
//   ALM_CNT     out saturating count of accepted alarms
//   BUSY        out high whenever the sequencer is not idle
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module parity_alarm_seq
  import parity_alarm_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES = PA_RST_CYCLES_DEF,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             CLK2,
  input  logic             PR_RST,
  input  logic             PARALM,
  input  logic             ALM_INH,
  input  logic             ALM_ACK,
  output logic             CLR_PAR_ALM,
  output logic             RESTART_REQ,
  output logic             ALM_LAMP,
  output logic [CNT_W-1:0] ALM_CNT,
  output logic             BUSY
);

  localparam logic [PA_DCNT_W-1:0] LOAD_RST  = pa_load(RST_CYCLES);
  localparam logic [PA_DCNT_W-1:0] LOAD_WAIT = pa_load(PA_WAIT_RETRY);

  logic pa_s;

  pa_state_e            state_q, state_d;
  logic [PA_DCNT_W-1:0] dcnt_q,  dcnt_d;
  logic                 req_q,   req_d;
  logic                 clr_n_q, clr_n_d;
  logic                 lamp_q,  lamp_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 busy_q,  busy_d;
  logic                 enter_restart;

  ng_sync2 u_sync (
    .clk_i  (CLK2),
    .rst_ni (PR_RST),
    .d_i    (PARALM),
    .q_o    (pa_s)
  );

  // The second consecutive synchronized high accepts the alarm.
  assign enter_restart = (state_q == ST_QUAL) && pa_s;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    req_d   = req_q;
    clr_n_d = 1'b1;
    lamp_d  = lamp_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pa_s && !ALM_INH) state_d = ST_QUAL;
      end
      ST_QUAL: begin
        if (pa_s) begin
          state_d = ST_RESTART;
          dcnt_d  = LOAD_RST;
          req_d   = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESTART: begin
        if (dcnt_q == '0) begin
          state_d = ST_CLEAR;
          req_d   = 1'b0;
          clr_n_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d = ST_WAITLOW;
        dcnt_d  = LOAD_WAIT;
      end
      ST_WAITLOW: begin
        if (!pa_s) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == '0) begin
          // Alarm latch did not release: clear again without recounting.
          state_d = ST_CLEAR;
          clr_n_d = 1'b0;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    // A new alarm outranks an acknowledge arriving in the same cycle.
    if (ALM_ACK)       lamp_d = 1'b0;
    if (enter_restart) lamp_d = 1'b1;
  end

  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge CLK2 or negedge PR_RST) begin
    if (!PR_RST) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      req_q   <= 1'b0;
      clr_n_q <= 1'b1;
      lamp_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      req_q   <= req_d;
      clr_n_q <= clr_n_d;
      lamp_q  <= lamp_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign CLR_PAR_ALM = clr_n_q;
  assign RESTART_REQ = req_q;
  assign ALM_LAMP    = lamp_q;
  assign ALM_CNT     = cnt_q;
  assign BUSY        = busy_q;

endmodule
